vga_display_timing: RTL and testbench
=====================================

Name: vga_display_timing

Overview:
- Generates 640x480@60 Hz VGA raster timing from the 100 MHz system clock, which the codebase names `clk`.
- Internal clock-enable divider (÷4) produces the 25 MHz pixel rate.
- Outputs pixel coordinates `sx`/`sy` plus active-low hsync/vsync and data-enable.
- Sits between the clock source and the pixel/colour generator, which keys off `sx`, `sy` and `de`.

Parameters:
- CLK_DIV, 4, system clocks per pixel (≥1).
- H_ACTIVE, 640, visible pixels per line.
- H_FP, 16, horizontal front porch (pixels).
- H_SYNC, 96, hsync pulse width (pixels).
- H_BP, 48, horizontal back porch (pixels).
- V_ACTIVE, 480, visible lines.
- V_FP, 10, vertical front porch (lines).
- V_SYNC, 2, vsync pulse width (lines).
- V_BP, 33, vertical back porch (lines).

Ports:
- clk  input  1  system clock, 100 MHz.
- rst  input  1  synchronous reset, active-high.
- hsync  output  1  horizontal sync, active-low.
- vsync  output  1  vertical sync, active-low.
- sx  output  10  current pixel column, 0..H_TOTAL-1.
- sy  output  10  current line, 0..V_TOTAL-1.
- de  output  1  high when sx<H_ACTIVE and sy<V_ACTIVE.
- pix_tick  output  1  one-clk pulse marking the clock on which the counters advance.
- line_start, frame_start  output  1 each  only when FRAME_STROBE_EN is defined (see Optional Feature).

Behaviour:
- Derived totals: H_TOTAL = H_ACTIVE+H_FP+H_SYNC+H_BP = 800; V_TOTAL = V_ACTIVE+V_FP+V_SYNC+V_BP = 525.
- All state changes on the rising edge of `clk`.
- `rst` sampled synchronously; it overrides every other action.
- Reset values: div=0, sx=0, sy=0, hsync=1, vsync=1, de=1, pix_tick=0. These are consistent with position (0,0).
- Divider:
  - Counts 0..CLK_DIV-1 and wraps.
  - pix_tick=1 while div==CLK_DIV-1.
  - With CLK_DIV=1, pix_tick is constantly 1 out of reset.
- Counters advance only on clocks where pix_tick=1:
  - sx increments; at H_TOTAL-1 it wraps to 0 and sy increments.
  - When sx wraps and sy==V_TOTAL-1, sy wraps to 0.
- Each sx value is held exactly CLK_DIV clocks, including the first after reset release.
- Line = 800×4 = 3200 clk = 32.0 µs. Frame = 525 lines = 1,680,000 clk = 16.8 ms.
- hsync=0 iff H_ACTIVE+H_FP ≤ sx < H_ACTIVE+H_FP+H_SYNC, i.e. sx 656..751.
- vsync=0 iff V_ACTIVE+V_FP ≤ sy < V_ACTIVE+V_FP+V_SYNC, i.e. sy 490..491.
- hsync, vsync and de are registered:
  - Decoded from next-state counter values.
  - Always correspond to the sx/sy presented in the same cycle; zero skew between coordinates and syncs.
- No combinational path from `rst` to any output.
- Reset mid-line or mid-frame: the next clock returns to reset values and the raster restarts at (0,0).
- sx/sy never exceed H_TOTAL-1/V_TOTAL-1 in any cycle.

Optional Feature:
- Macro: FRAME_STROBE_EN.
- When defined, two extra registered outputs are present:
  - line_start=1 for the CLK_DIV clocks during which sx==0.
  - frame_start=1 for the CLK_DIV clocks during which sx==0 and sy==0.
  - Both are asserted during reset.
- When undefined, these ports and their logic are absent. All other behaviour is identical.

Test Plan:
- Reset: hold rst=1 for 30 clk → sx=0, sy=0, hsync=1, vsync=1, de=1, pix_tick=0 throughout.
- Pixel pacing: release rst → sx=0 for clocks 1–4 after release, sx=1 for clocks 5–8. pix_tick pulses on every 4th clock.
- Hsync placement: hsync falls at sx=656, 2624 clk (26.24 µs) after release. Low for 384 clk, rises at sx=752. Period 3200 clk; de falls at sx=640.
- Line wrap: at sx=799→0, sy increments 0→1. Over the first 100 µs after release, sy reaches 3, with 3 complete hsync pulses.
- Vsync/frame wrap: vsync low exactly while sy=490..491 (6400 clk). sy wraps 524→0 at 1,680,000 clk. de=0 for all sy≥480.
- Mid-frame reset with FRAME_STROBE_EN: assert rst at sy=200 → next clk sx=sy=0. After release, frame_start=1 for 4 clk; line_start pulses every 3200 clk.

Source files
------------

// File: rtl/vga_display_timing.sv
// 640x480@60 VGA raster timing with a /CLK_DIV pixel clock-enable.
// Optional FRAME_STROBE_EN macro adds line_start/frame_start strobes.
module vga_display_timing #(
    parameter int CLK_DIV  = 4,
    parameter int H_ACTIVE = 640,
    parameter int H_FP     = 16,
    parameter int H_SYNC   = 96,
    parameter int H_BP     = 48,
    parameter int V_ACTIVE = 480,
    parameter int V_FP     = 10,
    parameter int V_SYNC   = 2,
    parameter int V_BP     = 33
) (
    input  logic       clk,
    input  logic       rst,
    output logic       hsync,
    output logic       vsync,
    output logic [9:0] sx,
    output logic [9:0] sy,
    output logic       de,
    output logic       pix_tick
`ifdef FRAME_STROBE_EN
    ,
    output logic       line_start,
    output logic       frame_start
`endif
);

    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int DW      = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

    localparam logic [DW-1:0] DIV_MAX = DW'(CLK_DIV - 1);
    localparam logic [9:0] H_LAST   = 10'(H_TOTAL - 1);
    localparam logic [9:0] V_LAST   = 10'(V_TOTAL - 1);
    localparam logic [9:0] H_VIS    = 10'(H_ACTIVE);
    localparam logic [9:0] V_VIS    = 10'(V_ACTIVE);
    localparam logic [9:0] HS_START = 10'(H_ACTIVE + H_FP);
    localparam logic [9:0] HS_END   = 10'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [9:0] VS_START = 10'(V_ACTIVE + V_FP);
    localparam logic [9:0] VS_END   = 10'(V_ACTIVE + V_FP + V_SYNC);

    logic [DW-1:0] div;
    logic [DW-1:0] div_next;
    logic          tick;
    logic [9:0]    sx_next;
    logic [9:0]    sy_next;

    // Next divider and raster position; counters move on the last divider phase.
    always_comb begin
        tick     = (div == DIV_MAX);
        div_next = tick ? '0 : div + 1'b1;
        sx_next  = sx;
        sy_next  = sy;
        if (tick) begin
            if (sx == H_LAST) begin
                sx_next = '0;
                sy_next = (sy == V_LAST) ? '0 : sy + 1'b1;
            end else begin
                sx_next = sx + 1'b1;
            end
        end
    end

    // Registered position; syncs decoded from the next position so they align with sx/sy.
    always_ff @(posedge clk) begin
        if (rst) begin
            div      <= '0;
            sx       <= '0;
            sy       <= '0;
            hsync    <= 1'b1;
            vsync    <= 1'b1;
            de       <= 1'b1;
            pix_tick <= 1'b0;
        end else begin
            div      <= div_next;
            sx       <= sx_next;
            sy       <= sy_next;
            hsync    <= !(sx_next >= HS_START && sx_next < HS_END);
            vsync    <= !(sy_next >= VS_START && sy_next < VS_END);
            de       <= (sx_next < H_VIS) && (sy_next < V_VIS);
            pix_tick <= (div_next == DIV_MAX);
        end
    end

`ifdef FRAME_STROBE_EN
    // Strobes held for every clock the raster sits at column 0 / origin.
    always_ff @(posedge clk) begin
        if (rst) begin
            line_start  <= 1'b1;
            frame_start <= 1'b1;
        end else begin
            line_start  <= (sx_next == '0);
            frame_start <= (sx_next == '0) && (sy_next == '0);
        end
    end
`endif

endmodule

// File: tb/tb_vga_display_timing.sv
// Randomised reset/run bench for vga_display_timing against an arithmetic raster model.
// One full-size instance plus a shrunken one so frame wrap and vsync are reached quickly.
module tb_vga_display_timing;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic       a_hsync, a_vsync, a_de, a_tick;
    logic [9:0] a_sx, a_sy;
    logic       b_hsync, b_vsync, b_de, b_tick;
    logic [9:0] b_sx, b_sy;
`ifdef FRAME_STROBE_EN
    logic a_ls, a_fs, b_ls, b_fs;
`endif

    vga_display_timing dut_a (
        .clk(clk), .rst(rst),
        .hsync(a_hsync), .vsync(a_vsync),
        .sx(a_sx), .sy(a_sy),
        .de(a_de), .pix_tick(a_tick)
`ifdef FRAME_STROBE_EN
        , .line_start(a_ls), .frame_start(a_fs)
`endif
    );

    vga_display_timing #(
        .CLK_DIV(3),
        .H_ACTIVE(16), .H_FP(4), .H_SYNC(6), .H_BP(4),
        .V_ACTIVE(12), .V_FP(2), .V_SYNC(2), .V_BP(3)
    ) dut_b (
        .clk(clk), .rst(rst),
        .hsync(b_hsync), .vsync(b_vsync),
        .sx(b_sx), .sy(b_sy),
        .de(b_de), .pix_tick(b_tick)
`ifdef FRAME_STROBE_EN
        , .line_start(b_ls), .frame_start(b_fs)
`endif
    );

    int vecs = 0;
    int errs = 0;
    int n    = 0;

    typedef struct {
        int sx, sy, hs, vs, de, tk, ls, fs;
    } ref_t;

    // Position is just elapsed clocks since reset divided down.
    function automatic ref_t model(input int t, input int dv,
                                   input int ha, input int hf, input int hw, input int hb,
                                   input int va, input int vf, input int vw, input int vb);
        ref_t r;
        int ht, vt, p, x, y;
        ht = ha + hf + hw + hb;
        vt = va + vf + vw + vb;
        p  = t / dv;
        x  = p % ht;
        y  = (p / ht) % vt;
        r.sx = x;
        r.sy = y;
        r.hs = (x >= ha + hf && x < ha + hf + hw) ? 0 : 1;
        r.vs = (y >= va + vf && y < va + vf + vw) ? 0 : 1;
        r.de = (x < ha && y < va) ? 1 : 0;
        r.tk = ((t % dv) == dv - 1) ? 1 : 0;
        r.ls = (x == 0) ? 1 : 0;
        r.fs = (x == 0 && y == 0) ? 1 : 0;
        return r;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vecs++;
        if (obs !== exp) begin
            errs++;
            $display("FAIL %s n=%0d got=%0d exp=%0d", tag, n, obs, exp);
        end
    endtask

    task automatic check_all();
        ref_t ra, rb;
        ra = model(n, 4, 640, 16, 96, 48, 480, 10, 2, 33);
        rb = model(n, 3, 16, 4, 6, 4, 12, 2, 2, 3);
        chk("a_sx", 32'(a_sx), ra.sx);
        chk("a_sy", 32'(a_sy), ra.sy);
        chk("a_hsync", 32'(a_hsync), ra.hs);
        chk("a_vsync", 32'(a_vsync), ra.vs);
        chk("a_de", 32'(a_de), ra.de);
        chk("a_pix_tick", 32'(a_tick), ra.tk);
        chk("b_sx", 32'(b_sx), rb.sx);
        chk("b_sy", 32'(b_sy), rb.sy);
        chk("b_hsync", 32'(b_hsync), rb.hs);
        chk("b_vsync", 32'(b_vsync), rb.vs);
        chk("b_de", 32'(b_de), rb.de);
        chk("b_pix_tick", 32'(b_tick), rb.tk);
`ifdef FRAME_STROBE_EN
        chk("a_line_start", 32'(a_ls), ra.ls);
        chk("a_frame_start", 32'(a_fs), ra.fs);
        chk("b_line_start", 32'(b_ls), rb.ls);
        chk("b_frame_start", 32'(b_fs), rb.fs);
`endif
    endtask

    // One clock: drive rst, advance the elapsed-clock count, check at negedge.
    task automatic step(input logic r);
        if (errs >= 200) return;
        rst = r;
        @(posedge clk);
        n = r ? 0 : n + 1;
        @(negedge clk);
        check_all();
    endtask

    initial begin
        int len;
        repeat (30) step(1'b1);
        repeat (20000) step(1'b0);
        for (int k = 0; k < 12; k++) begin
            len = $urandom_range(300, 3000);
            repeat (len) step(1'b0);
            len = $urandom_range(1, 4);
            repeat (len) step(1'b1);
        end
        repeat (4000) step(1'b0);
        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end

endmodule
